uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial UART receiver (8N1; 8E1 with UART_RX_PARITY_EN). Consumes the line driven by uart_tx.
//   Synchronises the async rx input, detects the start bit and samples each bit at mid-period.
//   Delivers each received byte as a parallel word with a one-cycle valid strobe.
//   Sits between the board RX pin (or uart_tx.tx in loopback) and the command/data consumer.
// PARAMETERS
//   CLK_FREQ   12_000_000  system clock frequency, Hz
//   BAUD_RATE  9_600       line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (1250 at defaults)
// PORTS
//   clk         in   1  system clock, rising edge
//   reset_n     in   1  asynchronous, active-low reset
//   rx          in   1  serial line, idle high, asynchronous to clk
//   data_out    out  8  last correctly framed byte, LSB received first
//   rx_valid    out  1  one-cycle pulse: data_out updated this cycle
//   frame_err   out  1  one-cycle pulse: stop bit sampled low
//   rx_busy     out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//   - Reset: data_out=8'h00, rx_valid=0, frame_err=0, rx_busy=0, sync flops=1, state=IDLE, counters=0.
//   - rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; STOP error path -> BREAK -> IDLE.
//   - IDLE: on rx_s==0 go START, clear baud counter, assert rx_busy.
//   - START: after CLKS_PER_BIT/2 clocks sample rx_s; 0 -> DATA (bit_idx=0); 1 -> false start, IDLE.
//   - DATA: every CLKS_PER_BIT clocks sample rx_s into shift reg bit bit_idx; after bit 7 -> STOP (or PARITY).
//   - STOP: sample after CLKS_PER_BIT. rx_s==1 -> data_out<=shift reg, rx_valid=1 for one cycle, IDLE.
//     rx_s==0 -> frame_err=1 for one cycle, data_out unchanged, go BREAK.
//   - BREAK: wait for rx_s==1, then IDLE (a held-low line yields exactly one frame_err, no repeats).
//   - Latency: rx_valid asserts <=3 clks after the stop-bit midpoint (2 sync + 1 register).
//   - Back-to-back frames: IDLE re-entered mid stop bit, so a start edge right after stop is caught.
//   - Baud counter width = $clog2(CLKS_PER_BIT); counter wraps to 0 at CLKS_PER_BIT-1, never overflows.
//   - rx_valid and frame_err never high in the same cycle; no input handshake, consumer must
//     accept data_out on rx_valid (data_out held until the next good frame).
//   - reset_n low mid-frame: immediate return to reset values; partial byte discarded, no strobe.
// CONFIGURATION
//   UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples bit 9 at mid-period;
//     extra port parity_err (out, 1, one-cycle pulse, reset 0) when XOR(data, parity)!=0;
//     on parity error rx_valid is NOT asserted, data_out unchanged; stop bit still checked.
//   Not defined: 8N1, no PARITY state, no parity_err port.
// TESTING
//   1. Reset, send 0xA5 8N1 at 9600 baud -> one rx_valid pulse, data_out=8'hA5, frame_err=0.
//   2. 0x42 then 0x00 back-to-back (no idle gap) -> two rx_valid pulses, 8'h42 then 8'h00.
//   3. rx low 300 clks then high (glitch < half bit) -> no rx_valid, rx_busy drops, state IDLE.
//   4. 0x3C with stop bit forced 0, line held low 3 bit times -> one frame_err, no rx_valid,
//      data_out retains previous value; next good 0x55 -> rx_valid, data_out=8'h55.
//   5. reset_n low during bit 4 of 0xFF -> outputs at reset values; next 0x81 received correctly.
//   6. Loopback with uart_tx (tx->rx), bytes 0x00,0xFF,0xA5,0x5A -> each received equal to sent.
//   7. UART_RX_PARITY_EN: 0xA5 with parity 0 -> rx_valid; with parity 1 -> parity_err only.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Double-flop synchronised rx, mid-bit sampling, one-cycle rx_valid / frame_err strobes.
module uart_rx #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 9_600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_meta;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit;
`endif

  // Synchroniser flops idle high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end

        // Half a bit in, the line must still be low or the edge was a glitch.
        START: begin
          if (baud_cnt == HALF_CNT) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt           <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt   <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        // Deciding at mid stop bit lets IDLE catch a start edge right after it.
        STOP: begin
          if (baud_cnt == LAST_CNT) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if ((^shift_reg) ^ parity_bit) begin
                parity_err <= 1'b1;
              end else begin
                data_out <= shift_reg;
                rx_valid <= 1'b1;
              end
`else
              data_out <= shift_reg;
              rx_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        BREAK: begin
          baud_cnt <= '0;
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; strobes are counted on the falling edge.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int CLK_FREQ  = 160_000;
  localparam int BAUD_RATE = 10_000;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       force_bad_parity = 1'b0;
  int         parity_count = 0;
`endif

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int frame_count = 0;
  int busy_count = 0;
  int overlap_count = 0;
  int valid_base = 0;
  int frame_base = 0;
  int busy_base = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] loop_bytes [4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_count++;
      last_data = data_out;
    end
    if (frame_err) frame_count++;
    if (rx_busy) busy_count++;
    if (rx_valid && frame_err) overlap_count++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) parity_count++;
    if (parity_err && (rx_valid || frame_err)) overlap_count++;
`endif
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleClocks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b, input int clocks);
    rx = b;
    repeat (clocks) @(negedge clk);
  endtask

  // One frame, LSB first; the stop bit level is a parameter for framing-error tests.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    sendBit(1'b0, CPB);
    for (int i = 0; i < 8; i++) sendBit(data[i], CPB);
`ifdef UART_RX_PARITY_EN
    sendBit((^data) ^ force_bad_parity, CPB);
`endif
    sendBit(stop_bit, CPB);
  endtask

  task automatic markCounts();
    valid_base = valid_count;
    frame_base = frame_count;
    busy_base  = busy_count;
  endtask

  task automatic frameCheck(input string tag, input int exp_valid, input int exp_ferr,
                            input logic [7:0] exp_data);
    checkOutput({tag, "_valid"}, valid_count - valid_base, exp_valid);
    checkOutput({tag, "_ferr"}, frame_count - frame_base, exp_ferr);
    checkOutput({tag, "_data"}, int'(data_out), int'(exp_data));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_data", int'(data_out), 0);
    checkOutput("reset_valid", int'(rx_valid), 0);
    checkOutput("reset_ferr", int'(frame_err), 0);
    checkOutput("reset_busy", int'(rx_busy), 0);
    reset_n = 1'b1;
    idleClocks(2 * CPB);

    // Single good frame
    markCounts();
    applyStimulus(8'hA5, 1'b1);
    idleClocks(4);
    frameCheck("a5", 1, 0, 8'hA5);
    checkOutput("a5_busy_seen", int'(busy_count != busy_base), 1);
    checkOutput("a5_busy_end", int'(rx_busy), 0);

    // Back-to-back frames with no idle gap
    idleClocks(CPB);
    markCounts();
    applyStimulus(8'h42, 1'b1);
    checkOutput("b2b_first", int'(last_data), 8'h42);
    applyStimulus(8'h00, 1'b1);
    idleClocks(4);
    frameCheck("b2b", 2, 0, 8'h00);

    // Glitch shorter than half a bit is a false start
    idleClocks(CPB);
    markCounts();
    sendBit(1'b0, 5);
    idleClocks(2 * CPB);
    frameCheck("glitch", 0, 0, 8'h00);
    checkOutput("glitch_busy", int'(rx_busy), 0);

    // Stop bit low followed by a held-low line gives one frame error
    markCounts();
    applyStimulus(8'h3C, 1'b0);
    sendBit(1'b0, 3 * CPB);
    idleClocks(2 * CPB);
    frameCheck("ferr", 0, 1, 8'h00);
    checkOutput("ferr_busy", int'(rx_busy), 0);
    markCounts();
    applyStimulus(8'h55, 1'b1);
    idleClocks(4);
    frameCheck("after_ferr", 1, 0, 8'h55);

    // Reset in the middle of bit 4 of 0xFF
    idleClocks(CPB);
    markCounts();
    sendBit(1'b0, CPB);
    for (int i = 0; i < 4; i++) sendBit(1'b1, CPB);
    sendBit(1'b1, CPB / 2);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_data", int'(data_out), 0);
    checkOutput("mid_reset_busy", int'(rx_busy), 0);
    checkOutput("mid_reset_valid", valid_count - valid_base, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idleClocks(2 * CPB);
    markCounts();
    applyStimulus(8'h81, 1'b1);
    idleClocks(4);
    frameCheck("after_reset", 1, 0, 8'h81);

    // Loopback-style byte stream
    for (int i = 0; i < 4; i++) begin
      markCounts();
      applyStimulus(loop_bytes[i], 1'b1);
      idleClocks(CPB);
      checkOutput($sformatf("loop%0d_valid", i), valid_count - valid_base, 1);
      checkOutput($sformatf("loop%0d_data", i), int'(data_out), int'(loop_bytes[i]));
    end

`ifdef UART_RX_PARITY_EN
    begin
      int p0;
      p0 = parity_count;
      markCounts();
      force_bad_parity = 1'b0;
      applyStimulus(8'hA5, 1'b1);
      idleClocks(4);
      frameCheck("par_ok", 1, 0, 8'hA5);
      checkOutput("par_ok_perr", parity_count - p0, 0);
      idleClocks(CPB);
      markCounts();
      force_bad_parity = 1'b1;
      applyStimulus(8'h3C, 1'b1);
      idleClocks(4);
      force_bad_parity = 1'b0;
      frameCheck("par_bad", 0, 0, 8'hA5);
      checkOutput("par_bad_perr", parity_count - p0, 1);
    end
`endif

    checkOutput("strobe_overlap", overlap_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
